reg_file_wb_sb: RTL and testbench
=================================

Name: reg_file_wb_sb

Overview:
- Architectural integer register file that consumes the write-back stage outputs (write enable, write address, write data) and serves the decode stage's two read ports.
- Bypasses a same-cycle WB write through to the read data.
- Includes a pending-write scoreboard. Long-latency writers (loads) mark their destination register at issue. Decode stalls on a read of a marked register until WB retires it.
- Sits between the MEM/WB pipeline register and the ID stage.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers; x0 included.
- AW, 5, register address width; must equal clog2(NREG).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- wb_we  in  1  write-back register write enable
- wb_wa  in  AW  write-back destination register
- wb_wdata  in  XLEN  write-back data
- id_ra1  in  AW  read address, port 1
- id_ra2  in  AW  read address, port 2
- id_use1  in  1  decode instruction actually consumes port 1
- id_use2  in  1  decode instruction actually consumes port 2
- id_rdata1  out  XLEN  read data, port 1 (combinational)
- id_rdata2  out  XLEN  read data, port 2 (combinational)
- iss_valid  in  1  an instruction leaves decode this cycle
- iss_late  in  1  issuing instruction's result arrives only at WB (load)
- iss_wa  in  AW  issuing instruction's destination register
- id_stall  out  1  decode must hold: a used source is pending
- sb_busy  out  1  at least one scoreboard bit is set

Behaviour:
- Reset (rst_n low, asynchronous):
  - All NREG registers clear to 0; all pending bits clear.
  - id_stall = 0 and sb_busy = 0 while in reset.
  - id_rdata1/2 reflect the cleared array (0), except for a same-cycle bypass.
  - Reset release is synchronous to clk.
- Write:
  - On the rising edge with wb_we=1 and wb_wa!=0, regs[wb_wa] <= wb_wdata.
  - Writes to x0 are discarded.
- Read (combinational, zero latency):
  - ra==0 -> 0.
  - Else if wb_we and wb_wa==ra -> wb_wdata (bypass).
  - Else regs[ra].
  - Both ports are independent; both may address the same register.
- Scoreboard pending[NREG]; pending[0] is held at 0:
  - Set: at the edge when iss_valid and iss_late and iss_wa!=0, pending[iss_wa] <= 1.
  - Clear: at the edge when wb_we, pending[wb_wa] <= 0.
  - Same register set and cleared in the same edge: set wins. The younger writer is still outstanding.
  - Non-late issues (ALU results) never touch the scoreboard. Forwarding covers them elsewhere.
- Stall (combinational):
  - id_stall = (id_use1 and hit1) or (id_use2 and hit2).
  - hitN = pending[raN] and not (wb_we and wb_wa==raN).
  - A register whose pending writer retires this cycle does not stall; the bypass supplies it.
  - ra==0 never stalls.
  - Stall is independent of iss_valid. The decode/control logic deasserts iss_valid while id_stall=1.
- sb_busy = OR of all pending bits (registered state only).
- Latency:
  - Write visible through bypass in the same cycle; from the array on the next cycle.
  - Pending visible to id_stall one cycle after issue.
- Only one write per cycle exists, so there are no write-write conflicts.
- Mid-operation reset: the array and scoreboard are lost. Upstream must not issue WB writes for pre-reset instructions.

Decomposition:
- Shared package (cpu_pkg): XLEN, NREG, AW, constant REG_ZERO = 5'd0.
- One natural sub-module: reg_scoreboard. It holds the pending bit vector, the set/clear/priority logic, hit detection for both ports, and sb_busy.
- The array and bypass muxes stay in the top module.

Test Plan:
- Reset then read: rst_n low 2 cycles, release; read ra1=5, ra2=31 -> both 0, id_stall=0, sb_busy=0.
- Write/readback and x0:
  - Stimulus: wb_we=1, wa=7, wdata=0xDEADBEEF; then wa=0, wdata=0x1234.
  - Required: ra1=7 reads 0xDEADBEEF in the write cycle (bypass) and after; ra2=0 reads 0 throughout.
- Load-use stall:
  - Stimulus: issue iss_late=1, iss_wa=9; next cycle id_ra1=9, id_use1=1.
  - Required: id_stall=1, sb_busy=1.
  - Stimulus: wb_we=1, wa=9, wdata=0x55.
  - Required: id_stall=0 and id_rdata1=0x55 in that cycle; next cycle sb_busy=0.
- Unused operand:
  - Stimulus: pending on r9, id_ra2=9, id_use2=0.
  - Required: id_stall=0.
- Set-clear collision:
  - Stimulus: r4 pending; in one edge, wb_we wa=4 and iss_late iss_wa=4.
  - Required: pending[4] stays 1, and a read of r4 with use next cycle -> id_stall=1.
- Async reset mid-flight:
  - Stimulus: r3 pending and r3 holding 0xA5A5A5A5; assert rst_n low between clock edges.
  - Required: immediately id_stall=0 and sb_busy=0; after release, r3 reads 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared register-file widths and constants
package cpu_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW = $clog2(NREG);
  localparam logic [AW-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: pending-write bits for long-latency writers, with per-port hit detection
module reg_scoreboard
  import cpu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_set,
  input  logic [AW-1:0] i_set_wa,
  input  logic          i_clr,
  input  logic [AW-1:0] i_clr_wa,
  input  logic [AW-1:0] i_ra1,
  input  logic [AW-1:0] i_ra2,
  input  logic          i_use1,
  input  logic          i_use2,
  output logic          o_stall,
  output logic          o_busy
);
  logic [NREG-1:0] r_pending;
  logic [NREG-1:0] w_set_mask;
  logic [NREG-1:0] w_clr_mask;
  logic            w_hit1;
  logic            w_hit2;

  // Set is applied after clear so a younger load to the same register stays outstanding.
  always_comb begin
    w_set_mask = (i_set && i_set_wa != REG_ZERO) ? NREG'(1) << i_set_wa : '0;
    w_clr_mask = i_clr ? NREG'(1) << i_clr_wa : '0;
    w_hit1 = r_pending[i_ra1] && !(i_clr && i_clr_wa == i_ra1);
    w_hit2 = r_pending[i_ra2] && !(i_clr && i_clr_wa == i_ra2);
    o_stall = (i_use1 && w_hit1) || (i_use2 && w_hit2);
    o_busy = |r_pending;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pending <= '0;
    else r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
  end
endmodule

// File: rtl/reg_file_wb_sb.sv
// reg_file_wb_sb: integer register file with WB bypass and load scoreboard for decode stalls
module reg_file_wb_sb
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_wb_we,
  input  logic [AW-1:0]   i_wb_wa,
  input  logic [XLEN-1:0] i_wb_wdata,
  input  logic [AW-1:0]   i_id_ra1,
  input  logic [AW-1:0]   i_id_ra2,
  input  logic            i_id_use1,
  input  logic            i_id_use2,
  output logic [XLEN-1:0] o_id_rdata1,
  output logic [XLEN-1:0] o_id_rdata2,
  input  logic            i_iss_valid,
  input  logic            i_iss_late,
  input  logic [AW-1:0]   i_iss_wa,
  output logic            o_id_stall,
  output logic            o_sb_busy
);
  logic [XLEN-1:0] r_regs [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    else if (i_wb_we && i_wb_wa != REG_ZERO) r_regs[i_wb_wa] <= i_wb_wdata;
  end

  always_comb begin
    o_id_rdata1 = (i_id_ra1 == REG_ZERO) ? '0 :
                  (i_wb_we && i_wb_wa == i_id_ra1) ? i_wb_wdata : r_regs[i_id_ra1];
    o_id_rdata2 = (i_id_ra2 == REG_ZERO) ? '0 :
                  (i_wb_we && i_wb_wa == i_id_ra2) ? i_wb_wdata : r_regs[i_id_ra2];
  end

  reg_scoreboard u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_set    (i_iss_valid && i_iss_late),
    .i_set_wa (i_iss_wa),
    .i_clr    (i_wb_we),
    .i_clr_wa (i_wb_wa),
    .i_ra1    (i_id_ra1),
    .i_ra2    (i_id_ra2),
    .i_use1   (i_id_use1),
    .i_use2   (i_id_use2),
    .o_stall  (o_id_stall),
    .o_busy   (o_sb_busy)
  );
endmodule

// File: tb/tb_reg_file_wb_sb.sv
// tb_reg_file_wb_sb: directed stimulus checked every cycle against an array/bitset model
module tb_reg_file_wb_sb;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        wb_we = 0;
  logic [4:0]  wb_wa = 0;
  logic [31:0] wb_wdata = 0;
  logic [4:0]  ra1 = 0, ra2 = 0;
  logic        use1 = 0, use2 = 0;
  logic [31:0] rdata1, rdata2;
  logic        iss_valid = 0, iss_late = 0;
  logic [4:0]  iss_wa = 0;
  logic        stall, busy;
  int checks = 0, errors = 0;
  bit en = 0;

  logic [31:0] m_regs [32];
  bit          m_pend [32];

  reg_file_wb_sb dut (
    .clk(clk), .rst_n(rst_n),
    .i_wb_we(wb_we), .i_wb_wa(wb_wa), .i_wb_wdata(wb_wdata),
    .i_id_ra1(ra1), .i_id_ra2(ra2), .i_id_use1(use1), .i_id_use2(use2),
    .o_id_rdata1(rdata1), .o_id_rdata2(rdata2),
    .i_iss_valid(iss_valid), .i_iss_late(iss_late), .i_iss_wa(iss_wa),
    .o_id_stall(stall), .o_sb_busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] <= 0;
        m_pend[i] <= 0;
      end
    end else begin
      if (wb_we && wb_wa != 0) m_regs[wb_wa] <= wb_wdata;
      if (wb_we) m_pend[wb_wa] <= 0;
      if (iss_valid && iss_late && iss_wa != 0) m_pend[iss_wa] <= 1;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] ra);
    if (ra == 0) return 0;
    if (wb_we && wb_wa == ra) return wb_wdata;
    return m_regs[ra];
  endfunction

  function automatic bit exp_wait(input logic [4:0] ra, input logic u);
    return u && ra != 0 && m_pend[ra] && !(wb_we && wb_wa == ra);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (en) begin
      bit any;
      any = 0;
      for (int i = 0; i < 32; i++) any |= m_pend[i];
      chk("model_rdata1", rdata1, exp_rd(ra1));
      chk("model_rdata2", rdata2, exp_rd(ra2));
      chk("model_stall", {31'b0, stall}, {31'b0, exp_wait(ra1, use1) || exp_wait(ra2, use2)});
      chk("model_busy", {31'b0, busy}, {31'b0, any});
    end
  end

  task automatic edge_in();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    en = 1;
    ra1 = 5; ra2 = 31;
    settle();
    chk("reset_rd1", rdata1, 32'h0);
    chk("reset_rd2", rdata2, 32'h0);
    chk("reset_stall", {31'b0, stall}, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);

    edge_in();
    wb_we = 1; wb_wa = 7; wb_wdata = 32'hDEADBEEF; ra1 = 7; ra2 = 0;
    settle();
    chk("bypass_r7", rdata1, 32'hDEADBEEF);
    chk("x0_rd_a", rdata2, 32'h0);
    edge_in();
    wb_wa = 0; wb_wdata = 32'h1234;
    settle();
    chk("array_r7", rdata1, 32'hDEADBEEF);
    chk("x0_bypass", rdata2, 32'h0);
    edge_in();
    wb_we = 0;
    settle();
    chk("x0_after", rdata2, 32'h0);

    edge_in();
    iss_valid = 1; iss_late = 1; iss_wa = 9; ra1 = 9;
    edge_in();
    iss_valid = 0; iss_late = 0; use1 = 1;
    settle();
    chk("loaduse_stall", {31'b0, stall}, 32'h1);
    chk("loaduse_busy", {31'b0, busy}, 32'h1);
    edge_in();
    wb_we = 1; wb_wa = 9; wb_wdata = 32'h55;
    settle();
    chk("retire_nostall", {31'b0, stall}, 32'h0);
    chk("retire_bypass", rdata1, 32'h55);
    edge_in();
    wb_we = 0; use1 = 0;
    settle();
    chk("retire_busy", {31'b0, busy}, 32'h0);

    edge_in();
    iss_valid = 1; iss_late = 1; iss_wa = 9;
    edge_in();
    iss_valid = 0; iss_late = 0; ra2 = 9; use2 = 0; ra1 = 0; use1 = 1;
    settle();
    chk("unused_nostall", {31'b0, stall}, 32'h0);
    chk("unused_busy", {31'b0, busy}, 32'h1);
    edge_in();
    wb_we = 1; wb_wa = 9; wb_wdata = 32'h99;
    edge_in();
    wb_we = 0; use1 = 0;

    iss_valid = 1; iss_late = 1; iss_wa = 4;
    edge_in();
    wb_we = 1; wb_wa = 4; wb_wdata = 32'h44;
    edge_in();
    wb_we = 0; iss_valid = 0; iss_late = 0; ra1 = 4; use1 = 1;
    settle();
    chk("collide_stall", {31'b0, stall}, 32'h1);
    chk("collide_data", rdata1, 32'h44);
    edge_in();
    wb_we = 1; wb_wa = 4; wb_wdata = 32'h45; use1 = 0;
    edge_in();
    wb_we = 0;

    wb_we = 1; wb_wa = 3; wb_wdata = 32'hA5A5A5A5;
    iss_valid = 1; iss_late = 1; iss_wa = 3;
    edge_in();
    wb_we = 0; iss_valid = 0; iss_late = 0; ra1 = 3; use1 = 1;
    settle();
    chk("pre_rst_stall", {31'b0, stall}, 32'h1);
    chk("pre_rst_data", rdata1, 32'hA5A5A5A5);
    rst_n = 0;
    #1;
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_data", rdata1, 32'h0);
    edge_in();
    rst_n = 1;
    settle();
    chk("post_rst_r3", rdata1, 32'h0);
    chk("post_rst_stall", {31'b0, stall}, 32'h0);
    edge_in();
    use1 = 0;
    settle();
    en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
